// File: rtl/uart_packet_sequencer.sv
// uart_packet_sequencer: frames the UART byte stream into XOR-checksummed packets and
// streams verified payloads to the modulator. Define PKT_STATS_EN for event counters.
module uart_packet_sequencer #(
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  uart_word,
    input  logic        uart_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
`ifdef PKT_STATS_EN
    output logic [15:0] stat_ok,
    output logic [15:0] stat_csum_err,
    output logic [15:0] stat_len_err,
    output logic [15:0] stat_timeout,
`endif
    output logic        busy,
    output logic        pkt_drop
);

    localparam int         PTR_W     = $clog2(MAX_LEN + 1);
    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [8:0] MAX_LEN_B = 9'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHECK, S_SEND} state_e;
    typedef enum logic [1:0] {DROP_NONE, DROP_LEN, DROP_CSUM, DROP_TIMEOUT} drop_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   len_q, len_d;
    logic [7:0]         csum_q, csum_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_next;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, rd_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_last_q, tx_last_d;
    logic               pkt_drop_q, pkt_drop_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               strobe_q, strobe_d;
    logic               buf_we, in_frame, timed_out;
    drop_e              drop_cause;
    logic [7:0]         pkt_buf_q [MAX_LEN];

    logic [7:0] rx_byte;
    logic       unused_word_msb;
    assign rx_byte         = uart_word[7:0];
    assign unused_word_msb = uart_word[8];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        csum_d     = csum_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        tx_last_d  = tx_last_q;
        buf_we     = 1'b0;
        drop_cause = DROP_NONE;
        strobe_d   = sync2_q & ~sync3_q;
        wr_next    = wr_ptr_q + PTR_W'(1);
        rd_next    = rd_ptr_q + PTR_W'(1);
        in_frame   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
        timed_out  = in_frame && !strobe_q && (cnt_q == CNT_W'(TIMEOUT - 1));
        cnt_d      = (in_frame && !strobe_q && !timed_out) ? cnt_q + CNT_W'(1) : '0;

        case (state_q)
            S_HUNT: begin
                if (strobe_q && rx_byte == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (strobe_q) begin
                    if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_LEN_B) begin
                        drop_cause = DROP_LEN;
                    end else begin
                        len_d    = rx_byte[PTR_W-1:0];
                        csum_d   = rx_byte;
                        wr_ptr_d = '0;
                        state_d  = S_PAYLOAD;
                    end
                end else if (timed_out) begin
                    drop_cause = DROP_TIMEOUT;
                end
            end
            S_PAYLOAD: begin
                if (strobe_q) begin
                    buf_we   = 1'b1;
                    csum_d   = csum_q ^ rx_byte;
                    wr_ptr_d = wr_next;
                    if (wr_next == len_q) state_d = S_CHECK;
                end else if (timed_out) begin
                    drop_cause = DROP_TIMEOUT;
                end
            end
            S_CHECK: begin
                if (strobe_q) begin
                    if (rx_byte == csum_q) begin
                        rd_ptr_d   = '0;
                        tx_data_d  = pkt_buf_q[0];
                        tx_valid_d = 1'b1;
                        tx_last_d  = (len_q == PTR_W'(1));
                        state_d    = S_SEND;
                    end else begin
                        drop_cause = DROP_CSUM;
                    end
                end else if (timed_out) begin
                    drop_cause = DROP_TIMEOUT;
                end
            end
            S_SEND: begin
                // The next beat is preloaded on each accept so beats stream back-to-back.
                if (tx_valid_q && tx_ready) begin
                    if (tx_last_q) begin
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        state_d    = S_HUNT;
                    end else begin
                        rd_ptr_d  = rd_next;
                        tx_data_d = pkt_buf_q[rd_next[IDX_W-1:0]];
                        tx_last_d = (rd_next == len_q - PTR_W'(1));
                    end
                end
            end
            default: state_d = S_HUNT;
        endcase

        pkt_drop_d = (drop_cause != DROP_NONE);
        if (pkt_drop_d) state_d = S_HUNT;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HUNT;
            len_q      <= '0;
            csum_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            pkt_drop_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            pkt_drop_q <= pkt_drop_d;
            sync1_q    <= uart_ready;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            strobe_q   <= strobe_d;
        end
    end

    // NOTE: the packet buffer is not reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (buf_we) pkt_buf_q[wr_ptr_q[IDX_W-1:0]] <= rx_byte;
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign pkt_drop = pkt_drop_q;
    assign busy     = (state_q != S_HUNT);

`ifdef PKT_STATS_EN
    logic [15:0] stat_ok_q, stat_ok_d;
    logic [15:0] stat_csum_q, stat_csum_d;
    logic [15:0] stat_len_q, stat_len_d;
    logic [15:0] stat_to_q, stat_to_d;
    logic        ok_evt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    assign ok_evt = (state_q == S_SEND) && tx_valid_q && tx_ready && tx_last_q;

    always_comb begin
        stat_ok_d   = sat_inc(stat_ok_q, ok_evt);
        stat_csum_d = sat_inc(stat_csum_q, drop_cause == DROP_CSUM);
        stat_len_d  = sat_inc(stat_len_q, drop_cause == DROP_LEN);
        stat_to_d   = sat_inc(stat_to_q, drop_cause == DROP_TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok_q   <= '0;
            stat_csum_q <= '0;
            stat_len_q  <= '0;
            stat_to_q   <= '0;
        end else begin
            stat_ok_q   <= stat_ok_d;
            stat_csum_q <= stat_csum_d;
            stat_len_q  <= stat_len_d;
            stat_to_q   <= stat_to_d;
        end
    end

    assign stat_ok       = stat_ok_q;
    assign stat_csum_err = stat_csum_q;
    assign stat_len_err  = stat_len_q;
    assign stat_timeout  = stat_to_q;
`endif

endmodule
